// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// EX-stage execution block for the pipelined MIPS datapath. Decodes alu_op/func
// into a 4-bit ALU control code, computes single-cycle integer results, and runs
// iterative MULT/MULTU/DIV/DIVU (one bit per cycle) into the HI/LO registers.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   valid_in        operation presented (accepted when !busy)
//   alu_op, func    operation selector / R-type function field
//   a, b            operands (rs, rt/imm)
//   ctrl_out        registered ALU control code of the last accepted op
//   result          registered single-cycle result
//   result_valid    result valid this cycle
//   illegal         last accepted op was undecodable
//   busy            multi-cycle op in progress; upstream must hold
//   done            one-cycle pulse when HI/LO were just written
//   hi, lo          HI/LO register contents
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [3:0]       ctrl_out,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             illegal,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [3:0] C_ADD  = 4'b0000;
    localparam logic [3:0] C_SUB  = 4'b0001;
    localparam logic [3:0] C_AND  = 4'b0010;
    localparam logic [3:0] C_NOR  = 4'b0011;
    localparam logic [3:0] C_OR   = 4'b0100;
    localparam logic [3:0] C_SLT  = 4'b0101;
    localparam logic [3:0] C_MFHI = 4'b0110;
    localparam logic [3:0] C_MFLO = 4'b0111;
    localparam logic [3:0] C_ILL  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    // Returns {illegal, ctrl}; every undecoded encoding maps to {1, 1111}.
    function automatic logic [4:0] decode_op(input logic [1:0] op, input logic [5:0] fn);
        logic [4:0] d;
        d = {1'b1, C_ILL};
        case (op)
            2'b00: begin
                case (fn)
                    6'b100000: d = {1'b0, C_ADD};
                    6'b100010: d = {1'b0, C_SUB};
                    6'b100100: d = {1'b0, C_AND};
                    6'b100111: d = {1'b0, C_NOR};
                    6'b100101: d = {1'b0, C_OR};
                    6'b101010: d = {1'b0, C_SLT};
                    6'b010000: d = {1'b0, C_MFHI};
                    6'b010010: d = {1'b0, C_MFLO};
                    6'b011000: d = {1'b0, 4'b1000};
                    6'b011001: d = {1'b0, 4'b1001};
                    6'b011010: d = {1'b0, 4'b1010};
                    6'b011011: d = {1'b0, 4'b1011};
                    default:   d = {1'b1, C_ILL};
                endcase
            end
            2'b01:   d = {1'b0, C_ADD};
            2'b10:   d = {1'b0, C_SUB};
            default: d = {1'b1, C_ILL};
        endcase
        return d;
    endfunction

    state_t             state_r;
    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH-1:0] acc_r;      // {partial/remainder, multiplier/quotient}
    logic [WIDTH-1:0]   opnd_r;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   a_r;        // original dividend, for divide-by-zero
    logic               is_div_r;
    logic               neg_q_r;    // negate product / quotient
    logic               neg_r_r;    // negate remainder
    logic               div0_r;
    logic [3:0]         ctrl_r;
    logic [WIDTH-1:0]   result_r;
    logic               result_valid_r;
    logic               illegal_r;
    logic               done_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic [4:0]         dec_s;
    logic [3:0]         ctrl_s;
    logic               illegal_s;
    logic               accept_s;
    logic               is_multi_s;
    logic               signed_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [WIDTH-1:0]   alu_res_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     shifted_s;
    logic [WIDTH:0]     diff_s;
    logic [2*WIDTH-1:0] iter_next_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   fix_hi_s;
    logic [WIDTH-1:0]   fix_lo_s;

    // Decode and operand preparation for the op currently presented.
    always_comb begin
        dec_s      = decode_op(alu_op, func);
        ctrl_s     = dec_s[3:0];
        illegal_s  = dec_s[4];
        accept_s   = valid_in && (state_r == ST_IDLE);
        is_multi_s = (ctrl_s[3:2] == 2'b10);
        // MULT/DIV have ctrl bit 0 clear; MULTU/DIVU have it set.
        signed_s   = !ctrl_s[0];
        if (signed_s && a[WIDTH-1]) begin
            a_mag_s = -a;
        end else begin
            a_mag_s = a;
        end
        if (signed_s && b[WIDTH-1]) begin
            b_mag_s = -b;
        end else begin
            b_mag_s = b;
        end
    end

    // Single-cycle ALU result; illegal and multi-cycle codes yield zero.
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        case (ctrl_s)
            C_ADD:   alu_res_s = a + b;
            C_SUB:   alu_res_s = a - b;
            C_AND:   alu_res_s = a & b;
            C_NOR:   alu_res_s = ~(a | b);
            C_OR:    alu_res_s = a | b;
            C_SLT:   alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            C_MFHI:  alu_res_s = hi_r;
            C_MFLO:  alu_res_s = lo_r;
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    // One shift-add or restoring-divide step, plus the final sign correction.
    always_comb begin
        sum_s     = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                    (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        shifted_s = acc_r[2*WIDTH-1:WIDTH-1];
        diff_s    = shifted_s - {1'b0, opnd_r};
        if (is_div_r) begin
            // A clear borrow bit means the trial subtraction fits.
            if (!diff_s[WIDTH]) begin
                iter_next_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end else begin
                iter_next_s = {shifted_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            iter_next_s = {sum_s, acc_r[WIDTH-1:1]};
        end

        prod_fix_s = neg_q_r ? -acc_r : acc_r;
        if (is_div_r) begin
            if (div0_r) begin
                fix_lo_s = {WIDTH{1'b1}};
                fix_hi_s = a_r;
            end else begin
                fix_lo_s = neg_q_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
                fix_hi_s = neg_r_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
            end
        end else begin
            fix_lo_s = prod_fix_s[WIDTH-1:0];
            fix_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
        end
    end

    // Control FSM with all registered outputs and HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            cnt_r          <= {CW{1'b0}};
            acc_r          <= {(2*WIDTH){1'b0}};
            opnd_r         <= {WIDTH{1'b0}};
            a_r            <= {WIDTH{1'b0}};
            is_div_r       <= 1'b0;
            neg_q_r        <= 1'b0;
            neg_r_r        <= 1'b0;
            div0_r         <= 1'b0;
            ctrl_r         <= 4'b0000;
            result_r       <= {WIDTH{1'b0}};
            result_valid_r <= 1'b0;
            illegal_r      <= 1'b0;
            done_r         <= 1'b0;
            hi_r           <= {WIDTH{1'b0}};
            lo_r           <= {WIDTH{1'b0}};
        end else begin
            done_r         <= 1'b0;
            result_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        ctrl_r    <= ctrl_s;
                        illegal_r <= illegal_s;
                        if (is_multi_s && !illegal_s) begin
                            is_div_r <= ctrl_s[1];
                            a_r      <= a;
                            div0_r   <= (b == {WIDTH{1'b0}});
                            neg_q_r  <= signed_s && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r_r  <= signed_s && a[WIDTH-1];
                            cnt_r    <= {CW{1'b0}};
                            state_r  <= ST_RUN;
                            if (ctrl_s[1]) begin
                                acc_r  <= {{WIDTH{1'b0}}, a_mag_s};
                                opnd_r <= b_mag_s;
                            end else begin
                                acc_r  <= {{WIDTH{1'b0}}, b_mag_s};
                                opnd_r <= a_mag_s;
                            end
                        end else begin
                            result_r       <= alu_res_s;
                            result_valid_r <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    acc_r <= iter_next_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi_r    <= fix_hi_s;
                    lo_r    <= fix_lo_s;
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign ctrl_out     = ctrl_r;
    assign result       = result_r;
    assign result_valid = result_valid_r;
    assign illegal      = illegal_r;
    assign busy         = (state_r != ST_IDLE);
    assign done         = done_r;
    assign hi           = hi_r;
    assign lo           = lo_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             valid_in;
    logic [1:0]       alu_op;
    logic [5:0]       func;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       ctrl_out;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             illegal;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int checks_cnt;
    int fail_cnt;
    int cyc_cnt;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .valid_in(valid_in),
        .alu_op(alu_op),
        .func(func),
        .a(a),
        .b(b),
        .ctrl_out(ctrl_out),
        .result(result),
        .result_valid(result_valid),
        .illegal(illegal),
        .busy(busy),
        .done(done),
        .hi(hi),
        .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Present one op for a single accepting edge; returns #1 after that edge.
    task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                         input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        @(negedge clk);
        valid_in = 1'b1;
        alu_op   = op;
        func     = fn;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    // Count cycles with busy high (starting right after acceptance), bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        rst_n      = 1'b0;
        valid_in   = 1'b0;
        alu_op     = 2'b00;
        func       = 6'b000000;
        a          = '0;
        b          = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_ctrl", 64'(ctrl_out), 64'h0);
        check_val("rst_result", 64'(result), 64'h0);
        check_val("rst_rv", 64'(result_valid), 64'h0);
        check_val("rst_busy", 64'(busy), 64'h0);
        check_val("rst_done", 64'(done), 64'h0);
        check_val("rst_hilo", {32'(hi), 32'(lo)}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle ALU ops
        issue(2'b00, F_ADD, 32'hFFFFFFFF, 32'h1);
        check_val("add_res", 64'(result), 64'h0);
        check_val("add_ctrl", 64'(ctrl_out), 64'h0);
        check_val("add_rv", 64'(result_valid), 64'h1);
        check_val("add_ill", 64'(illegal), 64'h0);
        @(posedge clk);
        #1;
        check_val("rv_pulse", 64'(result_valid), 64'h0);

        issue(2'b00, F_NOR, 32'h0, 32'h0);
        check_val("nor_res", 64'(result), 64'hFFFFFFFF);
        check_val("nor_ctrl", 64'(ctrl_out), 64'h3);
        issue(2'b00, F_SLT, 32'hFFFFFFFF, 32'h1);
        check_val("slt_res", 64'(result), 64'h1);
        issue(2'b10, 6'b000000, 32'h5, 32'h7);
        check_val("sub_res", 64'(result), 64'hFFFFFFFE);
        check_val("sub_ctrl", 64'(ctrl_out), 64'h1);

        // MULT -3 * 7, then MFLO in the done cycle
        issue(2'b00, F_MULT, 32'hFFFFFFFD, 32'h7);
        check_val("mult_ctrl", 64'(ctrl_out), 64'h8);
        check_val("mult_rv", 64'(result_valid), 64'h0);
        wait_idle(cyc_cnt);
        check_val("mult_busy_cycles", 64'(cyc_cnt), 64'd33);
        check_val("mult_done", 64'(done), 64'h1);
        check_val("mult_hi", 64'(hi), 64'hFFFFFFFF);
        check_val("mult_lo", 64'(lo), 64'hFFFFFFEB);
        issue(2'b00, F_MFLO, 32'h0, 32'h0);
        check_val("mflo_res", 64'(result), 64'hFFFFFFEB);
        check_val("mflo_ctrl", 64'(ctrl_out), 64'h7);

        // Divides
        issue(2'b00, F_DIV, 32'hFFFFFFF9, 32'h2);
        wait_idle(cyc_cnt);
        check_val("div_cycles", 64'(cyc_cnt), 64'd33);
        check_val("div_lo", 64'(lo), 64'hFFFFFFFD);
        check_val("div_hi", 64'(hi), 64'hFFFFFFFF);
        issue(2'b00, F_DIVU, 32'h7, 32'h0);
        wait_idle(cyc_cnt);
        check_val("div0_cycles", 64'(cyc_cnt), 64'd33);
        check_val("div0_lo", 64'(lo), 64'hFFFFFFFF);
        check_val("div0_hi", 64'(hi), 64'h7);
        issue(2'b00, F_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(cyc_cnt);
        check_val("divovf_lo", 64'(lo), 64'h80000000);
        check_val("divovf_hi", 64'(hi), 64'h0);

        // Stall: ADD ops during busy must be ignored
        issue(2'b00, F_MULTU, 32'h5, 32'h6);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            valid_in = (i % 2 == 0);
            alu_op   = 2'b00;
            func     = F_ADD;
            a        = 32'h11;
            b        = 32'h22;
            @(posedge clk);
            #1;
            check_val("stall_rv", 64'(result_valid), 64'h0);
            check_val("stall_ctrl", 64'(ctrl_out), 64'h9);
        end
        valid_in = 1'b0;
        wait_idle(cyc_cnt);
        check_val("multu_done", 64'(done), 64'h1);
        check_val("multu_lo", 64'(lo), 64'd30);
        check_val("multu_hi", 64'(hi), 64'h0);
        issue(2'b00, F_MULTU, 32'h3, 32'h4);
        check_val("b2b_busy", 64'(busy), 64'h1);
        check_val("b2b_rv", 64'(result_valid), 64'h0);
        wait_idle(cyc_cnt);
        check_val("b2b_cycles", 64'(cyc_cnt), 64'd33);
        check_val("b2b_lo", 64'(lo), 64'd12);

        // Illegal decodes
        issue(2'b00, F_ADD, 32'h1, 32'h2);
        check_val("add2_res", 64'(result), 64'h3);
        issue(2'b11, F_ADD, 32'h1, 32'h2);
        check_val("ill11_ctrl", 64'(ctrl_out), 64'hF);
        check_val("ill11_flag", 64'(illegal), 64'h1);
        check_val("ill11_res", 64'(result), 64'h0);
        check_val("ill11_rv", 64'(result_valid), 64'h1);
        issue(2'b00, F_ADD, 32'h4, 32'h4);
        check_val("add3_ill", 64'(illegal), 64'h0);
        issue(2'b00, 6'b111111, 32'h4, 32'h4);
        check_val("illfn_ctrl", 64'(ctrl_out), 64'hF);
        check_val("illfn_flag", 64'(illegal), 64'h1);
        check_val("illfn_res", 64'(result), 64'h0);
        check_val("illfn_rv", 64'(result_valid), 64'h1);

        // Reset in the middle of a DIV
        issue(2'b00, F_DIV, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #2;
        check_val("middiv_busy", 64'(busy), 64'h1);
        rst_n = 1'b0;
        #1;
        check_val("arst_busy", 64'(busy), 64'h0);
        check_val("arst_done", 64'(done), 64'h0);
        check_val("arst_hi", 64'(hi), 64'h0);
        check_val("arst_lo", 64'(lo), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(2'b00, F_ADD, 32'h2, 32'h3);
        check_val("post_add_res", 64'(result), 64'h5);
        check_val("post_add_rv", 64'(result_valid), 64'h1);
        check_val("post_add_busy", 64'(busy), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
